// File: rtl/sna_response_transmitter_if.sv
// Bundles the tag-push, AXI4-Lite response, VC flow-control and NoC flit
// signals of sna_response_transmitter.
interface sna_response_transmitter_if;
  logic        wr_tag_push;
  logic [3:0]  wr_tag;
  logic        rd_tag_push;
  logic [3:0]  rd_tag;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  is_on_off;
  logic [7:0]  is_allocatable;
  logic [31:0] flit_data;
  logic        flit_valid;
  logic        flit_head;
  logic        flit_tail;
  logic        tag_overflow;

  modport slave (
    input  wr_tag_push, wr_tag, rd_tag_push, rd_tag,
    input  bresp, bvalid, rdata, rresp, rvalid,
    input  is_on_off, is_allocatable,
    output bready, rready,
    output flit_data, flit_valid, flit_head, flit_tail, tag_overflow
  );

  modport master (
    output wr_tag_push, wr_tag, rd_tag_push, rd_tag,
    output bresp, bvalid, rdata, rresp, rvalid,
    output is_on_off, is_allocatable,
    input  bready, rready,
    input  flit_data, flit_valid, flit_head, flit_tail, tag_overflow
  );
endinterface

// File: rtl/sna_response_transmitter.sv
// Turns AXI4-Lite write/read responses into NoC response packets addressed by
// queued source tags. Define SNA_RESP_CODE_EN to carry bresp/rresp in the header.
module sna_response_transmitter #(
  parameter int TAG_DEPTH = 4
) (
  input logic                       clock,
  input logic                       reset,
  sna_response_transmitter_if.slave bus
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WHEAD, RHEAD, RDATA} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      push, pop, empty, full, drop;
  logic [1:0][3:0] push_tag, head_tag;
  logic            wr_cand, rd_cand, in_idle;
  logic            grant_wr, grant_rd;
  logic            rr_wr_first_reg;
  logic            overflow_reg;
  logic            vc_open, vc_alloc, head_ok;
  logic [3:0]      tag_reg;
  logic [31:0]     data_reg;
  logic [1:0]      resp_field;
  logic [31:0]     header;
  logic [31:0]     flit_data_reg, flit_data_next;
  logic            flit_valid_reg, flit_valid_next;
  logic            flit_head_reg, flit_head_next;
  logic            flit_tail_reg, flit_tail_next;

  // Index 0 is the write-tag FIFO, index 1 the read-tag FIFO.
  assign push        = {bus.rd_tag_push, bus.wr_tag_push};
  assign push_tag[0] = bus.wr_tag;
  assign push_tag[1] = bus.rd_tag;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [3:0]       mem [TAG_DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [CNT_W-1:0] count_reg;
      logic             do_push;

      assign full[gi]     = (count_reg == CNT_W'(TAG_DEPTH));
      assign empty[gi]    = (count_reg == '0);
      // A simultaneous pop frees the slot, so a push on full is only lost without one.
      assign do_push      = push[gi] & (~full[gi] | pop[gi]);
      assign drop[gi]     = push[gi] & full[gi] & ~pop[gi];
      assign head_tag[gi] = mem[rd_ptr_reg];

      always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_reg] <= push_tag[gi];
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({do_push, pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  assign wr_cand  = bus.bvalid & ~empty[0];
  assign rd_cand  = bus.rvalid & ~empty[1];
  assign in_idle  = (state_reg == IDLE) & ~reset;
  assign grant_wr = in_idle & wr_cand & (~rd_cand | rr_wr_first_reg);
  assign grant_rd = in_idle & rd_cand & (~wr_cand | ~rr_wr_first_reg);
  assign pop      = {grant_rd, grant_wr};

  assign bus.bready = grant_wr;
  assign bus.rready = grant_rd;

  assign vc_open  = bus.is_on_off[0];
  assign vc_alloc = bus.is_allocatable[0];
  assign head_ok  = vc_open & vc_alloc;

  // Priority only flips on contested grants, so an uncontested grant keeps the turn order.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_wr_first_reg <= 1'b1;
      overflow_reg    <= 1'b0;
    end else begin
      if (grant_wr & rd_cand)      rr_wr_first_reg <= 1'b0;
      else if (grant_rd & wr_cand) rr_wr_first_reg <= 1'b1;
      if (|drop) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (grant_wr) tag_reg <= head_tag[0];
    else if (grant_rd) tag_reg <= head_tag[1];
    if (grant_rd) data_reg <= bus.rdata;
  end

`ifdef SNA_RESP_CODE_EN
  logic [1:0] resp_reg;

  always_ff @(posedge clock) begin
    if (grant_wr) resp_reg <= bus.bresp;
    else if (grant_rd) resp_reg <= bus.rresp;
  end

  assign resp_field = resp_reg;
`else
  assign resp_field = 2'b00;
`endif

  assign header = {tag_reg, (state_reg == RHEAD), resp_field, 25'd0};

  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_wr)      state_next = WHEAD;
        else if (grant_rd) state_next = RHEAD;
      end
      WHEAD:   if (head_ok) state_next = IDLE;
      RHEAD:   if (head_ok) state_next = RDATA;
      RDATA:   if (vc_open) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    flit_valid_next = 1'b0;
    flit_head_next  = 1'b0;
    flit_tail_next  = 1'b0;
    flit_data_next  = '0;
    case (state_reg)
      WHEAD: begin
        if (head_ok) begin
          flit_valid_next = 1'b1;
          flit_head_next  = 1'b1;
          flit_tail_next  = 1'b1;
          flit_data_next  = header;
        end
      end
      RHEAD: begin
        if (head_ok) begin
          flit_valid_next = 1'b1;
          flit_head_next  = 1'b1;
          flit_data_next  = header;
        end
      end
      RDATA: begin
        if (vc_open) begin
          flit_valid_next = 1'b1;
          flit_tail_next  = 1'b1;
          flit_data_next  = data_reg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flit_valid_reg <= 1'b0;
      flit_head_reg  <= 1'b0;
      flit_tail_reg  <= 1'b0;
      flit_data_reg  <= '0;
    end else begin
      flit_valid_reg <= flit_valid_next;
      flit_head_reg  <= flit_head_next;
      flit_tail_reg  <= flit_tail_next;
      flit_data_reg  <= flit_data_next;
    end
  end

  assign bus.flit_valid   = flit_valid_reg;
  assign bus.flit_head    = flit_head_reg;
  assign bus.flit_tail    = flit_tail_reg;
  assign bus.flit_data    = flit_data_reg;
  assign bus.tag_overflow = overflow_reg;

endmodule

// File: tb/tb_sna_response_transmitter.sv
// Scoreboard bench for sna_response_transmitter: stimulus queues expected flits,
// a negedge monitor pops and compares every flit the DUT emits.
module tb_sna_response_transmitter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sna_response_transmitter_if bus();

  sna_response_transmitter #(.TAG_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        head;
    logic        tail;
  } flit_t;

  flit_t exp_q[$];
  flit_t mon_e;
  int checks   = 0;
  int failures = 0;

  function automatic logic [1:0] eresp(input logic [1:0] r);
`ifdef SNA_RESP_CODE_EN
    return r;
`else
    return 2'b00;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_flit(input logic [31:0] d, input logic h, input logic t);
    flit_t f;
    f.data = d;
    f.head = h;
    f.tail = t;
    exp_q.push_back(f);
  endtask

  task automatic exp_wr(input logic [3:0] tag, input logic [1:0] resp);
    expect_flit({tag, 1'b0, eresp(resp), 25'd0}, 1'b1, 1'b1);
  endtask

  task automatic exp_rd(input logic [3:0] tag, input logic [1:0] resp, input logic [31:0] d);
    expect_flit({tag, 1'b1, eresp(resp), 25'd0}, 1'b1, 1'b0);
    expect_flit(d, 1'b0, 1'b1);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_wr(input logic [3:0] t);
    bus.wr_tag_push = 1'b1;
    bus.wr_tag      = t;
    step();
    bus.wr_tag_push = 1'b0;
  endtask

  task automatic push_rd(input logic [3:0] t);
    bus.rd_tag_push = 1'b1;
    bus.rd_tag      = t;
    step();
    bus.rd_tag_push = 1'b0;
  endtask

  // Waits (bounded) for ready, checks it drops after the handshake, then drops valid.
  task automatic wait_hs(input bit is_rd, input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clock);
      if ((is_rd ? bus.rready : bus.bready) === 1'b1) seen = 1'b1;
      else n++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_handshake: got no ready within 60 cycles, required ready", name);
    end else begin
      @(posedge clock);
      @(negedge clock);
      chk({name, "_ready_one_cycle"}, 32'(is_rd ? bus.rready : bus.bready), 32'd0);
    end
    step();
    if (is_rd) bus.rvalid = 1'b0;
    else       bus.bvalid = 1'b0;
  endtask

  task automatic drive_wr(input logic [1:0] resp, input string name);
    bus.bresp  = resp;
    bus.bvalid = 1'b1;
    wait_hs(1'b0, name);
  endtask

  task automatic drive_rd(input logic [1:0] resp, input logic [31:0] d, input string name);
    bus.rresp  = resp;
    bus.rdata  = d;
    bus.rvalid = 1'b1;
    wait_hs(1'b1, name);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    step();
    chk({name, "_drain_remaining"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_bready"},     32'(bus.bready),       32'd0);
    chk({name, "_rready"},     32'(bus.rready),       32'd0);
    chk({name, "_flit_valid"}, 32'(bus.flit_valid),   32'd0);
    chk({name, "_flit_head"},  32'(bus.flit_head),    32'd0);
    chk({name, "_flit_tail"},  32'(bus.flit_tail),    32'd0);
    chk({name, "_flit_data"},  bus.flit_data,         32'd0);
    chk({name, "_overflow"},   32'(bus.tag_overflow), 32'd0);
  endtask

  always @(negedge clock) begin
    if (bus.flit_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL flit_unexpected: got data=%h head=%b tail=%b, required no flit",
                 bus.flit_data, bus.flit_head, bus.flit_tail);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.flit_data !== mon_e.data || bus.flit_head !== mon_e.head ||
            bus.flit_tail !== mon_e.tail) begin
          failures++;
          $display("FAIL flit_content: got data=%h head=%b tail=%b, required data=%h head=%b tail=%b",
                   bus.flit_data, bus.flit_head, bus.flit_tail, mon_e.data, mon_e.head, mon_e.tail);
        end
      end
    end else begin
      checks++;
      if ({bus.flit_data, bus.flit_head, bus.flit_tail} !== 34'd0) begin
        failures++;
        $display("FAIL flit_idle_zero: got data=%h head=%b tail=%b valid=%b, required all 0",
                 bus.flit_data, bus.flit_head, bus.flit_tail, bus.flit_valid);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    bus.wr_tag_push    = 1'b0;
    bus.wr_tag         = 4'h0;
    bus.rd_tag_push    = 1'b0;
    bus.rd_tag         = 4'h0;
    bus.bresp          = 2'b00;
    bus.bvalid         = 1'b1;
    bus.rdata          = 32'h0;
    bus.rresp          = 2'b00;
    bus.rvalid         = 1'b1;
    bus.is_on_off      = 8'h01;
    bus.is_allocatable = 8'h01;

    // Reset values, with valids high so ready gating is exercised.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_quiet("reset");
    step();
    reset      = 1'b0;
    bus.bvalid = 1'b0;
    bus.rvalid = 1'b0;

    // Single write response.
    push_wr(4'h3);
    exp_wr(4'h3, 2'b00);
    drive_wr(2'b00, "wr_basic");
    @(negedge clock);
    chk("wr_basic_header_latency", 32'(bus.flit_valid & bus.flit_head & bus.flit_tail), 32'd1);
    drain("wr_basic");

    // Read response: header then data.
    push_rd(4'h5);
    exp_rd(4'h5, 2'b10, 32'hDEAD_BEEF);
    drive_rd(2'b10, 32'hDEAD_BEEF, "rd_basic");
    drain("rd_basic");

    // Header held back while VC0 is not allocatable.
    push_rd(4'h9);
    bus.is_allocatable = 8'h00;
    exp_rd(4'h9, 2'b01, 32'h1234_5678);
    drive_rd(2'b01, 32'h1234_5678, "rd_stall");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("rd_stall_hold%0d", i), 32'(bus.flit_valid), 32'd0);
    end
    bus.is_allocatable = 8'h01;
    @(negedge clock);
    chk("rd_stall_header_release", 32'(bus.flit_valid & bus.flit_head), 32'd1);
    drain("rd_stall");

    // Contested arbitration: write first, then read first on the repeat.
    push_wr(4'h1);
    push_rd(4'h2);
    push_wr(4'h4);
    push_rd(4'h8);
    exp_wr(4'h1, 2'b11);
    exp_rd(4'h2, 2'b01, 32'hA5A5_0001);
    fork
      drive_wr(2'b11, "rr1_wr");
      drive_rd(2'b01, 32'hA5A5_0001, "rr1_rd");
    join
    drain("rr1");
    exp_rd(4'h8, 2'b00, 32'h5A5A_0002);
    exp_wr(4'h4, 2'b10);
    fork
      drive_wr(2'b10, "rr2_wr");
      drive_rd(2'b00, 32'h5A5A_0002, "rr2_rd");
    join
    drain("rr2");

    // Push and pop together on a full FIFO: both happen, no overflow.
    push_wr(4'h6);
    push_wr(4'h7);
    push_wr(4'h8);
    push_wr(4'h9);
    for (int t = 6; t <= 10; t++) exp_wr(4'(t), 2'b00);
    bus.bresp  = 2'b00;
    bus.bvalid = 1'b1;
    push_wr(4'hA);
    @(negedge clock);
    chk("full_pushpop_ready_drop", 32'(bus.bready), 32'd0);
    step();
    bus.bvalid = 1'b0;
    @(negedge clock);
    chk("full_pushpop_no_overflow", 32'(bus.tag_overflow), 32'd0);
    step();
    for (int t = 0; t < 4; t++) drive_wr(2'b00, $sformatf("full_pushpop_wr%0d", t));
    drain("full_pushpop");

    // Five pushes into a four-deep FIFO: one dropped, overflow sticks.
    for (int t = 1; t <= 5; t++) push_wr(4'(t));
    @(negedge clock);
    chk("overflow_set", 32'(bus.tag_overflow), 32'd1);
    step();
    exp_wr(4'h1, 2'b01);
    exp_wr(4'h2, 2'b10);
    exp_wr(4'h3, 2'b11);
    exp_wr(4'h4, 2'b00);
    drive_wr(2'b01, "ovf_wr1");
    drive_wr(2'b10, "ovf_wr2");
    drive_wr(2'b11, "ovf_wr3");
    drive_wr(2'b00, "ovf_wr4");
    drain("ovf");
    bus.bvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk($sformatf("empty_fifo_bready%0d", i), 32'(bus.bready), 32'd0);
      step();
    end
    bus.bvalid = 1'b0;
    @(negedge clock);
    chk("overflow_sticky", 32'(bus.tag_overflow), 32'd1);
    step();

    // Reset between read header and data abandons the packet.
    push_rd(4'hC);
    push_wr(4'h7);
    bus.is_allocatable = 8'h00;
    expect_flit({4'hC, 1'b1, eresp(2'b00), 25'd0}, 1'b1, 1'b0);
    drive_rd(2'b00, 32'hCAFE_F00D, "rst_mid");
    bus.is_allocatable = 8'h01;
    step();
    bus.is_on_off = 8'h00;
    @(negedge clock);
    chk("rst_mid_header_seen", 32'(bus.flit_valid & bus.flit_head), 32'd1);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_quiet("rst_mid_during");
    step();
    reset              = 1'b0;
    bus.is_on_off      = 8'h01;
    bus.is_allocatable = 8'h01;
    bus.bvalid         = 1'b1;
    bus.rvalid         = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk_quiet($sformatf("rst_mid_after%0d", i));
      step();
    end
    bus.bvalid = 1'b0;
    bus.rvalid = 1'b0;
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sna_response_transmitter.md
SNA_RESPONSE_TRANSMITTER -- requirements
Module: sna_response_transmitter

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 4, depth of each outstanding-tag FIFO (power of two, 2..16).
REQ-002 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 wr_tag_push  in  1 / wr_tag  in  4  push source node address of an issued write request.
REQ-005 rd_tag_push  in  1 / rd_tag  in  4  push source node address of an issued read request.
REQ-006 bresp  in  2 / bvalid  in  1 / bready  out  1  AXI4-Lite write-response channel.
REQ-007 rdata  in  32 / rresp  in  2 / rvalid  in  1 / rready  out  1  AXI4-Lite read-data channel.
REQ-008 is_on_off  in  8 / is_allocatable  in  8  downstream flow control; only bit 0 (VC0) used.
REQ-009 flit_data  out  32 / flit_valid  out  1 / flit_head  out  1 / flit_tail  out  1  NoC flit output.
REQ-010 tag_overflow  out  1  sticky: a tag push was dropped on a full FIFO.

Function
REQ-011 Two independent tag FIFOs (write, read), TAG_DEPTH entries each; push and pop in the same cycle SHALL both take effect, count unchanged.
REQ-012 Push to a full FIFO without simultaneous pop SHALL be dropped and set tag_overflow.
REQ-013 States: IDLE, WHEAD, RHEAD, RDATA.
REQ-014 In IDLE, write candidate = bvalid & write FIFO non-empty; read candidate = rvalid & read FIFO non-empty.
REQ-015 Both candidates: round-robin, write wins first after reset, winner gets lower priority next time.
REQ-016 Winner: corresponding ready SHALL be high for exactly that one cycle; resp/data and popped tag registered; next state WHEAD or RHEAD.
REQ-017 bready/rready SHALL be low in every state other than IDLE and whenever the matching FIFO is empty.
REQ-018 Header flit: [31:28] tag, [27] 1=read/0=write, [26:25] resp, [24:0] zero.
REQ-019 WHEAD/RHEAD: header sent (flit_valid=1, flit_head=1) only in a cycle with is_on_off[0]=1 and is_allocatable[0]=1; otherwise wait, flit_valid=0.
REQ-020 WHEAD: header also flit_tail=1; next IDLE.
REQ-021 RHEAD: flit_tail=0; next RDATA.
REQ-022 RDATA: flit_data=captured rdata, flit_tail=1, flit_head=0, sent in a cycle with is_on_off[0]=1 (is_allocatable ignored); next IDLE.
REQ-023 flit_valid SHALL be high for exactly one cycle per flit; flit outputs registered.
REQ-024 Latency: handshake at cycle N, header at N+1 earliest; read data flit at N+2 earliest; next handshake earliest one cycle after tail flit.
REQ-025 flit_data, flit_head, flit_tail SHALL be 0 whenever flit_valid=0.

Reset
REQ-026 reset high at a clock edge: state IDLE, both FIFOs emptied, round-robin to write, tag_overflow=0.
REQ-027 Reset output values: bready=0, rready=0, flit_valid=0, flit_head=0, flit_tail=0, flit_data=0.
REQ-028 Reset mid-packet SHALL abandon the packet; no further flits of it emitted.

Configuration
REQ-029 Macro SNA_RESP_CODE_EN defined: header bits [26:25] carry captured bresp/rresp.
REQ-030 SNA_RESP_CODE_EN undefined: header bits [26:25] forced 0; bresp/rresp unused.

Verification
REQ-031 wr_tag=4'h3 pushed; bvalid, bresp=2'b00, VC0 open -> bready 1 cycle, next cycle flit_data=32'h3000_0000, head=tail=1.
REQ-032 rd_tag=4'h5; rvalid, rdata=32'hDEAD_BEEF, rresp=2'b10, macro on -> header 32'h5C00_0000 (head), then 32'hDEAD_BEEF (tail).
REQ-033 Read header pending, is_allocatable[0]=0 for 3 cycles -> flit_valid=0 those 3 cycles, header on 4th.
REQ-034 bvalid and rvalid together, both tags present -> write packet first, then read; repeat -> read first.
REQ-035 5 write pushes, TAG_DEPTH=4 -> tag_overflow=1, only 4 write responses accepted; bvalid with empty FIFO -> bready stays 0.
REQ-036 reset asserted between read header and data -> no data flit, FIFOs empty, all outputs 0.
